comparator: RTL and testbench
=============================

COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..64.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands valid this cycle.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 out_valid  output  1  result flags valid.
REQ-008 a_greater  output  1  A > B.
REQ-009 a_equal  output  1  A == B.
REQ-010 a_less  output  1  A < B.
REQ-011 signed_mode  input  1  two's-complement compare; present only with COMPARATOR_SIGNED_EN defined.

Function
REQ-012 The block SHALL capture a, b and in_valid on each rising clk edge and present the result exactly 1 cycle later; outputs are registered with no combinational input-to-output path.
REQ-013 out_valid SHALL equal in_valid delayed by one cycle.
REQ-014 When out_valid=1, exactly one of a_greater, a_equal and a_less SHALL be 1.
REQ-015 When in_valid=0, the three flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 Default comparison SHALL be unsigned magnitude over all WIDTH bits; no width extension or truncation.
REQ-017 The compare SHALL be built MSB-first from 4-bit slices, each producing gt/eq, merged by a priority tree in which the most significant non-equal slice decides; WIDTH not divisible by 4 is zero-padded at the MSB in unsigned mode.
REQ-018 Back-to-back in_valid SHALL give one result per cycle with no bubbles; there is no backpressure.
REQ-019 Boundary: all-zero vs all-zero -> equal; all-ones vs zero -> greater (unsigned); identical nonzero patterns -> equal.

Reset
REQ-020 While rst=1 at a clk edge: out_valid=0, a_greater=0, a_equal=0, a_less=0; rst has priority over in_valid.
REQ-021 Operands sampled in the same cycle rst is asserted SHALL be discarded; the first valid result appears one cycle after the first in_valid=1 following rst deassertion.

Configuration
REQ-022 Macro COMPARATOR_SIGNED_EN defined: port signed_mode exists; with signed_mode=1 operands are two's complement (MSB is sign, padding is sign-extension); with signed_mode=0 behaviour matches REQ-016. signed_mode is sampled with the operands.
REQ-023 Macro COMPARATOR_SIGNED_EN undefined: no signed_mode port and unsigned compare only.

Structure
REQ-024 A shared package comparator_pkg SHALL hold the slice width constant (4), the slice-count function ceil(WIDTH/4), and the cmp_result_t enum (CMP_LT, CMP_EQ, CMP_GT).
REQ-025 One sub-module, comparator_slice, SHALL implement the 4-bit gt/eq compare and is instantiated ceil(WIDTH/4) times; the merge tree and output registers reside in comparator.

Verification
REQ-026 a=8'h00, b=8'h00, in_valid=1 -> next cycle out_valid=1, a_equal=1, others 0.
REQ-027 a=8'h01, b=8'h00, then a=8'h00, b=8'h01, then a=8'hFF, b=8'h00, then a=8'h00, b=8'hFF, back-to-back -> greater, less, greater, less on four consecutive cycles.
REQ-028 a=8'hAA, b=8'hAA -> equal; a=8'hAB, b=8'hAA -> greater (LSB slice decides); a=8'h1F, b=8'h20 -> less (MSB slice decides).
REQ-029 Assert rst with in_valid=1, a=8'h05, b=8'h03 -> out_valid=0 and all flags 0 on the following cycle; deassert rst -> result greater one cycle later.
REQ-030 in_valid=0 after a less result -> out_valid=0 and a_less stays 1.
REQ-031 With COMPARATOR_SIGNED_EN defined: signed_mode=1, a=8'hFF, b=8'h01 -> less; signed_mode=0 with the same operands -> greater.

Source files
------------

// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared slice width, slice count and result encoding for the comparator
package comparator_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    function automatic int slice_count(input int width);
        return (width + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// rtl/comparator_slice.sv - 4-bit unsigned greater/equal compare used as one slice of the merge tree
module comparator_slice
    import comparator_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output logic               gt_o,
    output logic               eq_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator.sv
// rtl/comparator.sv - registered magnitude comparator built from 4-bit slices
// COMPARATOR_SIGNED_EN adds the signed_mode port for two's-complement compares.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    output logic             a_greater,
    output logic             a_equal,
    output logic             a_less
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int PAD_W  = NSLICE * SLICE_W;

    logic [PAD_W-1:0]  a_pad;
    logic [PAD_W-1:0]  b_pad;
    logic [NSLICE-1:0] slice_gt;
    logic [NSLICE-1:0] slice_eq;
    logic              gt_m;
    logic              eq_m;
    cmp_result_t       res;
    logic              valid_d, valid_q;
    logic [2:0]        flags_d, flags_q;

    // Signed compare: sign-extend, then flip the sign bit so the unsigned slices order correctly.
    always_comb begin
        a_pad = PAD_W'(a);
        b_pad = PAD_W'(b);
`ifdef COMPARATOR_SIGNED_EN
        if (signed_mode) begin
            a_pad = PAD_W'($signed(a));
            b_pad = PAD_W'($signed(b));
            a_pad[PAD_W-1] = ~a_pad[PAD_W-1];
            b_pad[PAD_W-1] = ~b_pad[PAD_W-1];
        end
`endif
    end

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        comparator_slice u_slice (
            .a_i  (a_pad[i*SLICE_W +: SLICE_W]),
            .b_i  (b_pad[i*SLICE_W +: SLICE_W]),
            .gt_o (slice_gt[i]),
            .eq_o (slice_eq[i])
        );
    end

    // Walk LSB to MSB so the most significant non-equal slice has the final say.
    always_comb begin
        gt_m = 1'b0;
        eq_m = 1'b1;
        for (int i = 0; i < NSLICE; i++) begin
            if (!slice_eq[i]) begin
                gt_m = slice_gt[i];
            end
            eq_m = eq_m & slice_eq[i];
        end
    end

    always_comb begin
        res = CMP_LT;
        if (eq_m) begin
            res = CMP_EQ;
        end else if (gt_m) begin
            res = CMP_GT;
        end
        valid_d = in_valid;
        flags_d = flags_q;
        if (in_valid) begin
            case (res)
                CMP_GT:  flags_d = 3'b100;
                CMP_EQ:  flags_d = 3'b010;
                default: flags_d = 3'b001;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign a_greater = flags_q[2];
    assign a_equal   = flags_q[1];
    assign a_less    = flags_q[0];

endmodule

// File: tb/tb_comparator.sv
// tb/tb_comparator.sv - scoreboard bench for comparator; expectations queued at drive time
module tb_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       signed_mode = 1'b0;
    logic       out_valid, a_greater, a_equal, a_less;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t  sb[$];
    logic [2:0] hold_flags = 3'b000;

    always #5 clk = ~clk;

    comparator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .out_valid (out_valid),
        .a_greater (a_greater),
        .a_equal   (a_equal),
        .a_less    (a_less)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input logic sm);
        logic use_signed;
        logic gt;
        logic lt;
`ifdef COMPARATOR_SIGNED_EN
        use_signed = sm;
`else
        use_signed = 1'b0;
        if (sm) use_signed = 1'b0;
`endif
        if (use_signed) begin
            gt = $signed(x) > $signed(y);
            lt = $signed(x) < $signed(y);
        end else begin
            gt = x > y;
            lt = x < y;
        end
        return {gt, (x == y), lt};
    endfunction

    task automatic drive(input string tag, input logic r, input logic v,
                         input logic [7:0] x, input logic [7:0] y, input logic sm);
        sb_entry_t e;
        @(negedge clk);
        rst         = r;
        in_valid    = v;
        a           = x;
        b           = y;
        signed_mode = sm;
        if (r) begin
            hold_flags = 3'b000;
            e.exp = 4'b0000;
        end else begin
            if (v) hold_flags = model(x, y, sm);
            e.exp = {v, hold_flags};
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin : monitor
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, {28'd0, out_valid, a_greater, a_equal, a_less}, {28'd0, e.exp});
            end
        end
    end

    initial begin : stimulus
        logic [7:0] ra, rb;
        drive("reset0", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive("reset1", 1'b1, 1'b1, 8'h12, 8'h34, 1'b0);

        drive("zero_eq", 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        drive("b2b_gt1", 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        drive("b2b_lt1", 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
        drive("b2b_gtff", 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
        drive("b2b_ltff", 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
        drive("aa_eq", 1'b0, 1'b1, 8'hAA, 8'hAA, 1'b0);
        drive("lsb_slice", 1'b0, 1'b1, 8'hAB, 8'hAA, 1'b0);
        drive("msb_slice", 1'b0, 1'b1, 8'h1F, 8'h20, 1'b0);
        drive("hold_less", 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
        drive("hold_less2", 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0);
        drive("ff_eq", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        drive("mid_rst", 1'b1, 1'b1, 8'h05, 8'h03, 1'b0);
        drive("post_rst", 1'b0, 1'b1, 8'h05, 8'h03, 1'b0);

        drive("sm_lt", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b1);
        drive("sm_gt", 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
        drive("sm_neg", 1'b0, 1'b1, 8'h80, 8'h7F, 1'b1);
        drive("sm_pos", 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 5 == 0) ? ra : 8'($urandom_range(0, 255));
            drive("rand", 1'b0, 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)));
        end
        drive("idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
